// File: rtl/td4_board_pkg.sv
// Package: td4_board_pkg
// Shared constants and types for the TD4 board interface.
//   NUM_SW       - number of DIP switches feeding TD4 "sw"
//   step_state_e - manual single-step clock FSM states
package td4_board_pkg;

  localparam int unsigned NUM_SW = 4;

  typedef enum logic {
    STEP_IDLE = 1'b0,
    STEP_HIGH = 1'b1
  } step_state_e;

endpackage

// File: rtl/td4_input_conditioner_if.sv
// Interface: td4_input_conditioner_if
// Bundles the board-side inputs and TD4-side outputs of the input conditioner.
//   sw_raw_i      raw DIP switches (async, bouncing)
//   btn_raw_i     raw step push button (async, active-high)
//   manual_mode_i 1 = manual single-step clock, 0 = auto clock
//   auto_clk_i    divided clock from the normClkGenerator
//   sw_o          debounced switch levels -> TD4_top.sw
//   btn_o         debounced button level
//   btn_press_o   one-cycle pulse on the debounced button rising edge
//   step_clk_o    clock to TD4_top.clock
// Modports: slave = conditioner side, master = board/TD4 side.
interface td4_input_conditioner_if;
  import td4_board_pkg::*;

  logic [NUM_SW-1:0] sw_raw_i;
  logic              btn_raw_i;
  logic              manual_mode_i;
  logic              auto_clk_i;
  logic [NUM_SW-1:0] sw_o;
  logic              btn_o;
  logic              btn_press_o;
  logic              step_clk_o;

  modport slave (
    input  sw_raw_i, btn_raw_i, manual_mode_i, auto_clk_i,
    output sw_o, btn_o, btn_press_o, step_clk_o
  );

  modport master (
    output sw_raw_i, btn_raw_i, manual_mode_i, auto_clk_i,
    input  sw_o, btn_o, btn_press_o, step_clk_o
  );

endinterface

// File: rtl/input_debouncer.sv
// Module: input_debouncer
// One-bit 2-FF synchronizer followed by a run-length debouncer. A new level
// is accepted only after DEBOUNCE_CYCLES consecutive synced samples differ
// from the current stable level.
//   clk_in    system clock
//   reset_n   asynchronous active-low reset
//   raw_i     raw asynchronous input bit
//   level_d_o next-cycle stable level (the stable-level register's D input)
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_d_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter stops at C_LAST: reaching it accepts the level and clears it,
  // so it can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == C_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // The D side is exported so the parent can register outputs and detect
  // the rising edge in the same cycle the stable level changes.
  assign level_d_o = level_d;

endmodule

// File: rtl/td4_input_conditioner.sv
// Module: td4_input_conditioner
// Board-input side of the TD4 board interface. Debounces 4 DIP switches and
// the step button, generates a one-cycle press pulse, and produces the TD4
// clock: a fixed-width single-step pulse per press in manual mode, or the
// divided auto clock (one cycle delayed) in auto mode.
//   clk_in   system clock
//   reset_n  asynchronous active-low reset
//   bus      td4_input_conditioner_if.slave (raw inputs, mode, auto clock,
//            sw_o / btn_o / btn_press_o / step_clk_o)
module td4_input_conditioner
  import td4_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned STEP_HIGH_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  td4_input_conditioner_if.slave  bus
);

  localparam int unsigned HC_W = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(STEP_HIGH_CYCLES - 1);

  logic [NUM_SW:0]   raw_bits;
  logic [NUM_SW:0]   level_d;

  logic [NUM_SW-1:0] sw_q;
  logic              btn_q;
  logic              press_q, press_d;
  logic              step_q, step_d;
  step_state_e       state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;

  // Bits [NUM_SW-1:0] are the switches, bit NUM_SW is the button.
  assign raw_bits = {bus.btn_raw_i, bus.sw_raw_i};

  for (genvar i = 0; i <= NUM_SW; i++) begin : g_db
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .raw_i     (raw_bits[i]),
      .level_d_o (level_d[i])
    );
  end

  // btn_q holds the current stable level, so this fires exactly in the
  // first cycle btn_o reads 1.
  assign press_d = level_d[NUM_SW] & ~btn_q;

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    unique case (state_q)
      STEP_IDLE: begin
        if (press_q && bus.manual_mode_i) begin
          state_d = STEP_HIGH;
          hc_d    = HC_LOAD;
        end
      end
      STEP_HIGH: begin
        if (hc_q == '0) begin
          state_d = STEP_IDLE;
        end else begin
          hc_d = hc_q - HC_W'(1);
        end
      end
    endcase
  end

  // Using state_d keeps the registered step clock aligned with the HIGH state.
  assign step_d = bus.manual_mode_i ? (state_d == STEP_HIGH) : bus.auto_clk_i;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sw_q    <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      step_q  <= 1'b0;
      state_q <= STEP_IDLE;
      hc_q    <= '0;
    end else begin
      sw_q    <= level_d[NUM_SW-1:0];
      btn_q   <= level_d[NUM_SW];
      press_q <= press_d;
      step_q  <= step_d;
      state_q <= state_d;
      hc_q    <= hc_d;
    end
  end

  assign bus.sw_o        = sw_q;
  assign bus.btn_o       = btn_q;
  assign bus.btn_press_o = press_q;
  assign bus.step_clk_o  = step_q;

endmodule

// File: tb/tb_td4_input_conditioner.sv
// Testbench for td4_input_conditioner with DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3.
// Reference model: per-bit sliding window over the synchronized sample history
// (a level is accepted once the last D synced samples all disagree with it),
// plus a remaining-high-cycles count for the single-step pulse.
module tb_td4_input_conditioner;
  import td4_board_pkg::*;

  localparam int D  = 4;
  localparam int S  = 3;
  localparam int NB = NUM_SW + 1;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  td4_input_conditioner_if bus_if ();

  td4_input_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .STEP_HIGH_CYCLES (S)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model state, all values as seen just after a clock edge.
  logic [NB-1:0] hist [D+2];   // hist[0] = sample taken at the latest edge
  logic [NB-1:0] m_q;
  logic          m_press;
  logic          m_step;
  int            m_rem;

  int cyc = 0;
  int presses, highs, first_high, press_cyc;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < D + 2; j++) hist[j] = '0;
    m_q     = '0;
    m_press = 1'b0;
    m_step  = 1'b0;
    m_rem   = 0;
  endtask

  task automatic clr_counts();
    presses    = 0;
    highs      = 0;
    first_high = -1;
    press_cyc  = -1;
  endtask

  task automatic tick();
    logic [NB-1:0] raw, nq;
    logic          man, aut, all_diff;
    int            nrem;
    @(posedge clk_in);
    raw = {bus_if.btn_raw_i, bus_if.sw_raw_i};
    man = bus_if.manual_mode_i;
    aut = bus_if.auto_clk_i;
    if (reset_n) begin
      nrem = (m_rem > 0) ? m_rem - 1 : ((m_press && man) ? S : 0);
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
      nq = m_q;
      // Synced value lags the raw sample by two edges: window is hist[2..D+1].
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_q[b]) all_diff = 1'b0;
        if (all_diff) nq[b] = ~m_q[b];
      end
      m_press = nq[NB-1] & ~m_q[NB-1];
      m_q     = nq;
      m_rem   = nrem;
      m_step  = man ? (nrem > 0) : aut;
    end
    #1;
    cyc++;
    chk("sw_o",        bus_if.sw_o,        m_q[NUM_SW-1:0]);
    chk("btn_o",       bus_if.btn_o,       m_q[NB-1]);
    chk("btn_press_o", bus_if.btn_press_o, m_press);
    chk("step_clk_o",  bus_if.step_clk_o,  m_step);
    if (bus_if.btn_press_o === 1'b1) begin
      presses++;
      press_cyc = cyc;
    end
    if (bus_if.step_clk_o === 1'b1) begin
      highs++;
      if (first_high < 0) first_high = cyc;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n, sw_hold, btn_hold;

    bus_if.sw_raw_i      = 4'hF;
    bus_if.btn_raw_i     = 1'b0;
    bus_if.manual_mode_i = 1'b1;
    bus_if.auto_clk_i    = 1'b0;
    model_reset();
    clr_counts();

    // 1. Reset state and first-acceptance latency
    tick_n(3);
    chk("rst_sw_o", bus_if.sw_o, 4'h0);
    chk("rst_step_clk_o", bus_if.step_clk_o, 1'b0);
    reset_n = 1'b1;
    n = 0;
    while (bus_if.sw_o !== 4'hF && n < 20) begin
      tick();
      n++;
    end
    chk_rng("sw_latency", n, 5, 7);

    // 2. Short glitches on sw[0] are filtered, a stable change is accepted
    for (int len = 1; len <= 3; len++) begin
      bus_if.sw_raw_i[0] = 1'b0;
      tick_n(len);
      bus_if.sw_raw_i[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("glitch_hold", bus_if.sw_o, 4'hF);
      end
    end
    bus_if.sw_raw_i[0] = 1'b0;
    tick_n(8);
    chk("sw0_follow", bus_if.sw_o, 4'hE);

    // 3. Bouncing button then held: one press, one 3-cycle step pulse
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      bus_if.btn_raw_i = 1'b1;
      tick();
      bus_if.btn_raw_i = 1'b0;
      tick();
    end
    bus_if.btn_raw_i = 1'b1;
    tick_n(20);
    chk_rng("bounce_presses", presses, 1, 1);
    chk_rng("bounce_high_cycles", highs, S, S);
    chk_rng("step_after_press", first_high, press_cyc + 1, press_cyc + 1);

    // 4. Fresh press after returning to IDLE gives a new pulse
    bus_if.btn_raw_i = 1'b0;
    tick_n(10);
    clr_counts();
    bus_if.btn_raw_i = 1'b1;
    tick_n(15);
    chk_rng("fresh_presses", presses, 1, 1);
    chk_rng("fresh_high_cycles", highs, S, S);

    // Mode change mid-pulse, then auto->manual with button already held
    bus_if.btn_raw_i = 1'b0;
    tick_n(10);
    bus_if.btn_raw_i = 1'b1;
    n = 0;
    while (bus_if.step_clk_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk_rng("midpulse_wait", n, 1, 19);
    bus_if.manual_mode_i = 1'b0;
    tick_n(10);
    bus_if.manual_mode_i = 1'b1;
    clr_counts();
    tick_n(10);
    chk_rng("no_step_on_mode_return", highs, 0, 0);

    // 5. Auto mode: step clock follows auto_clk_i, presses ignored
    bus_if.manual_mode_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) bus_if.auto_clk_i = ~bus_if.auto_clk_i;
      if (i % 15 == 0) bus_if.btn_raw_i  = ~bus_if.btn_raw_i;
      tick();
    end
    bus_if.auto_clk_i    = 1'b0;
    bus_if.manual_mode_i = 1'b1;

    // 6. Reset mid-pulse, then release with button held
    bus_if.btn_raw_i = 1'b0;
    tick_n(10);
    bus_if.btn_raw_i = 1'b1;
    n = 0;
    while (bus_if.step_clk_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk_rng("reset_pulse_wait", n, 1, 19);
    reset_n = 1'b0;
    #1;
    chk("async_rst_step", bus_if.step_clk_o, 1'b0);
    chk("async_rst_btn", bus_if.btn_o, 1'b0);
    model_reset();
    tick_n(3);
    reset_n = 1'b1;
    clr_counts();
    n = 0;
    while (bus_if.btn_press_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk_rng("press_after_reset", n, 5, 7);
    tick_n(10);
    chk_rng("single_press_after_reset", presses, 1, 1);

    // Randomized traffic against the model
    sw_hold  = 0;
    btn_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (sw_hold == 0) begin
        bus_if.sw_raw_i = 4'($urandom_range(0, 15));
        sw_hold = int'($urandom_range(1, 8));
      end
      sw_hold--;
      if (btn_hold == 0) begin
        bus_if.btn_raw_i = 1'($urandom_range(0, 1));
        btn_hold = int'($urandom_range(1, 10));
      end
      btn_hold--;
      if (i % 50 == 0) bus_if.manual_mode_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus_if.auto_clk_i = ~bus_if.auto_clk_i;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
